mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the single-port word memory (mem).
//  Grants one requester at a time, drives one memory access per grant, and
//  returns read data with a one-cycle ack pulse.
//  Sits between the fetch/data masters (m0, m1) and mem.
//  mem samples on negedge clk; this block is fully posedge.
// PARAMETERS
//  ADDR_W      24  word address width (matches mem_addr)
//  DATA_W      32  data width (matches mem_din/mem_dout)
//  FIXED_PRIO  0   0 = round-robin between m0/m1; 1 = m0 always wins ties
// PORTS
//  clk        in   1       system clock, all state on posedge
//  rst        in   1       synchronous reset, active-high
//  m0_req     in   1       m0 request; held high until m0_ack
//  m0_we      in   1       m0 write (1) / read (0); stable while m0_req high
//  m0_addr    in   ADDR_W  m0 word address; stable while m0_req high
//  m0_wdata   in   DATA_W  m0 write data; stable while m0_req high
//  m0_ack     out  1       one-cycle completion pulse to m0
//  m0_rdata   out  DATA_W  m0 read data, valid when m0_ack=1, held until next m0 ack
//  m1_*       -    -       same set as m0_* for requester 1
//  busy       out  1       1 while state != IDLE
//  mem_enable out  1       to mem; registered
//  mem_write  out  1       to mem; registered
//  mem_addr   out  ADDR_W  to mem; registered
//  mem_din    out  DATA_W  to mem; registered
//  mem_dout   in   DATA_W  from mem; valid at the posedge after mem_enable cycle
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (m0 preferred), all outputs 0 incl. rdata regs.
//  FSM states:
//   IDLE -> BUSY on any req sampled high.
//    Winner: only requester high wins; if both are high, rr_ptr owner wins
//    (FIXED_PRIO=1: m0 wins).
//    On the transition edge, winner addr/we/wdata latch into mem_* regs,
//    mem_enable<=1, gnt_id<=winner.
//    rr_ptr<=~winner on every grant (ignored when FIXED_PRIO=1).
//   BUSY -> DONE unconditionally after 1 cycle.
//    mem performs the access at the mid-cycle negedge.
//    At the exit edge: mem_enable<=0, mem_write<=0,
//    gnt_id rdata<=mem_dout, gnt_id ack<=1.
//   DONE -> IDLE unconditionally; ack drops to 0.
//    Req is not sampled in DONE, so a req still high at the ack edge is not
//    regranted.
//  Latency: req seen at edge N -> mem access cycle N+1 -> ack high cycle N+2.
//   Max throughput: 1 access per 3 cycles.
//  Handshake: master drops req in the cycle after ack. If req stays high, IDLE
//   regrants it as a new transaction (repeat access), subject to arbitration.
//  Write: rdata on the write ack = pre-write content of that word
//   (mem read-before-write).
//  Non-granted requests wait; never dropped. Inputs may change only while req=0.
//  mem_addr/mem_din hold last values when idle; mem_enable=0 makes them don't-care.
//  No range check: full ADDR_W passed through; decode is mem's job.
//  Reset mid-BUSY/DONE: next edge IDLE, mem_enable=0, no ack issued,
//   rr_ptr=0, rdata cleared.
//   A write whose negedge already occurred is committed; the master must reissue.
//  m0_ack and m1_ack are never high in the same cycle.
//  ack only in DONE, busy=1 in BUSY/DONE.
// TESTING
//  1 rst=1 2 cycles with random reqs -> all outputs 0, busy=0, no mem_enable.
//  2 m0 write addr=5 data=32'hDEADBEEF, then read addr=5
//    -> ack 2 cycles after req edge, m0_rdata=32'hDEADBEEF.
//  3 m0,m1 req together, held after each ack, RR
//    -> grants m0,m1,m0,m1, one ack/3 cycles.
//    FIXED_PRIO=1 -> m0 only, m1 starves.
//  4 word 7=32'h11111111; m1 write 32'h22222222 to 7
//    -> m1_rdata=32'h11111111; later read -> 32'h22222222.
//  5 rst pulse in BUSY of m1 read -> no m1_ack, mem_enable=0 next cycle;
//    m1 reissue -> normal ack.
//  6 m1 req arrives while m0 BUSY -> m1 granted right after m0 DONE;
//    m0_rdata unchanged by m1 ack.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two masters, the arbiter and the word memory.
// slave = arbiter side, master = requester/memory environment side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              busy;
    logic              mem_enable;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_dout,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output busy, mem_enable, mem_write, mem_addr, mem_din
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_dout,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  busy, mem_enable, mem_write, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter/sequencer for a single-port word memory; req edge N -> mem access N+1 -> ack N+2.
// Backpressure: losing/late requests simply wait with req held; one access per 3 cycles at most.
module mem_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              gnt_id_q, gnt_id_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              win_id;
    req_t              m0_cmd, m1_cmd, win_cmd;

    assign m0_cmd  = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
    assign m1_cmd  = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};
    assign win_cmd = win_id ? m1_cmd : m0_cmd;

    // A lone requester always wins; ties go to rr_ptr owner, or m0 in fixed mode.
    always_comb begin
        win_id = bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            win_id = FIXED_PRIO ? 1'b0 : rr_ptr_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_id_d     = gnt_id_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d      = BUSY;
                    gnt_id_d     = win_id;
                    mem_enable_d = 1'b1;
                    mem_write_d  = win_cmd.we;
                    mem_addr_d   = win_cmd.addr;
                    mem_din_d    = win_cmd.wdata;
                    if (!FIXED_PRIO) begin
                        rr_ptr_d = ~win_id;
                    end
                end
            end
            BUSY: begin
                // mem did its access on the negedge inside this cycle, so mem_dout is valid now
                state_d      = DONE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
                if (gnt_id_q) begin
                    m1_rdata_d = bus.mem_dout;
                    m1_ack_d   = 1'b1;
                end else begin
                    m0_rdata_d = bus.mem_dout;
                    m0_ack_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            gnt_id_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_id_q     <= gnt_id_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.mem_enable = mem_enable_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.m0_ack     = m0_ack_q;
    assign bus.m1_ack     = m1_ack_q;
    assign bus.m0_rdata   = m0_rdata_q;
    assign bus.m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin instance with a negedge word-memory model,
// plus a fixed-priority instance used for the starvation case.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(24), .DATA_W(32)) bus ();
    mem_arbiter_if #(.ADDR_W(24), .DATA_W(32)) bus_fp ();

    mem_arbiter #(.ADDR_W(24), .DATA_W(32), .FIXED_PRIO(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mem_arbiter #(.ADDR_W(24), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp.slave)
    );

    // Word memory: negedge access, read-before-write
    logic [31:0] mem_arr [0:255];
    always @(negedge clk) begin
        if (bus.mem_enable === 1'b1) begin
            bus.mem_dout <= mem_arr[bus.mem_addr[7:0]];
            if (bus.mem_write === 1'b1) mem_arr[bus.mem_addr[7:0]] <= bus.mem_din;
        end
    end
    assign bus_fp.mem_dout = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic r, input logic we,
                           input logic [23:0] a, input logic [31:0] d);
        if (m == 0) begin
            bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    task automatic set_req_fp(input int m, input logic r, input logic [23:0] a);
        if (m == 0) begin
            bus_fp.m0_req = r; bus_fp.m0_we = 1'b0; bus_fp.m0_addr = a; bus_fp.m0_wdata = 32'h0;
        end else begin
            bus_fp.m1_req = r; bus_fp.m1_we = 1'b0; bus_fp.m1_addr = a; bus_fp.m1_wdata = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 24'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 24'h0, 32'h0);
        set_req_fp(0, 1'b0, 24'h0);
        set_req_fp(1, 1'b0, 24'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One complete transaction; lat counts posedges from req raise to visible ack (bounded).
    task automatic xact(input int m, input logic we, input logic [23:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
        logic ack;
        set_req(m, 1'b1, we, a, d);
        lat = 0;
        ack = 1'b0;
        while (!ack && lat < 20) begin
            tick();
            lat++;
            ack = (m == 0) ? bus.m0_ack : bus.m1_ack;
        end
        rd = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
        set_req(m, 1'b0, 1'b0, 24'h0, 32'h0);
        tick();
    endtask

    logic [31:0] rd;
    int          lat;
    logic [1:0]  code, code_fp, exp_code, exp_fp;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[10] = 32'hA0A0_A0A0;
        mem_arr[11] = 32'hB1B1_B1B1;
        bus.mem_dout = 32'h0;

        // 1: reset with random request activity
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            set_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom), $urandom);
            set_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom), $urandom);
            set_req_fp(0, 1'($urandom_range(0, 1)), 24'h3);
            set_req_fp(1, 1'($urandom_range(0, 1)), 24'h4);
            tick();
            check($sformatf("rst_ctl_c%0d", c),
                  {bus.busy, bus.mem_enable, bus.mem_write, bus.m0_ack, bus.m1_ack}, 5'b0);
            check($sformatf("rst_addr_c%0d", c), bus.mem_addr, 24'h0);
            check($sformatf("rst_din_c%0d", c), bus.mem_din, 32'h0);
            check($sformatf("rst_rdata_c%0d", c), {bus.m0_rdata, bus.m1_rdata}, 64'h0);
            check($sformatf("rst_fp_c%0d", c), {bus_fp.busy, bus_fp.mem_enable}, 2'b0);
        end
        do_reset();

        // 2: m0 write then read back
        xact(0, 1'b1, 24'd5, 32'hDEAD_BEEF, rd, lat);
        check("m0_wr_lat", lat, 2);
        check("m0_wr_rdata_prewrite", rd, 32'h0);
        xact(0, 1'b0, 24'd5, 32'h0, rd, lat);
        check("m0_rd_lat", lat, 2);
        check("m0_rd_rdata", rd, 32'hDEAD_BEEF);
        check("m0_rd_m1_untouched", bus.m1_rdata, 32'h0);

        // 3: both held -> RR alternates; fixed-priority instance starves m1
        do_reset();
        set_req(0, 1'b1, 1'b0, 24'd10, 32'h0);
        set_req(1, 1'b1, 1'b0, 24'd11, 32'h0);
        set_req_fp(0, 1'b1, 24'd10);
        set_req_fp(1, 1'b1, 24'd11);
        for (int i = 1; i <= 12; i++) begin
            tick();
            code     = {bus.m1_ack, bus.m0_ack};
            code_fp  = {bus_fp.m1_ack, bus_fp.m0_ack};
            exp_code = (i == 2 || i == 8) ? 2'b01 : (i == 5 || i == 11) ? 2'b10 : 2'b00;
            exp_fp   = (i % 3 == 2) ? 2'b01 : 2'b00;
            check($sformatf("rr_ack_t%0d", i), code, exp_code);
            check($sformatf("fp_ack_t%0d", i), code_fp, exp_fp);
            if (i == 2) check("rr_m0_rdata", bus.m0_rdata, 32'hA0A0_A0A0);
            if (i == 5) check("rr_m1_rdata", bus.m1_rdata, 32'hB1B1_B1B1);
        end
        set_req(0, 1'b0, 1'b0, 24'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 24'h0, 32'h0);
        set_req_fp(0, 1'b0, 24'h0);
        set_req_fp(1, 1'b0, 24'h0);
        tick();
        tick();
        check("rr_idle_after", bus.busy, 1'b0);

        // 4: m1 write returns old content, later read returns new
        xact(0, 1'b1, 24'd7, 32'h1111_1111, rd, lat);
        xact(1, 1'b1, 24'd7, 32'h2222_2222, rd, lat);
        check("m1_wr_lat", lat, 2);
        check("m1_wr_rdata_old", rd, 32'h1111_1111);
        xact(1, 1'b0, 24'd7, 32'h0, rd, lat);
        check("m1_rd_new", rd, 32'h2222_2222);

        // 5: reset during m1 BUSY aborts without ack, reissue works
        set_req(1, 1'b1, 1'b0, 24'd11, 32'h0);
        tick();
        check("abort_busy", {bus.busy, bus.mem_enable}, 2'b11);
        rst = 1'b1;
        tick();
        check("abort_no_ack", {bus.m0_ack, bus.m1_ack}, 2'b00);
        check("abort_idle", {bus.busy, bus.mem_enable}, 2'b00);
        check("abort_rdata_clr", bus.m1_rdata, 32'h0);
        set_req(1, 1'b0, 1'b0, 24'h0, 32'h0);
        rst = 1'b0;
        tick();
        xact(1, 1'b0, 24'd11, 32'h0, rd, lat);
        check("reissue_lat", lat, 2);
        check("reissue_rdata", rd, 32'hB1B1_B1B1);

        // 6: m1 arrives while m0 in BUSY -> granted at first IDLE edge after m0's DONE
        set_req(0, 1'b1, 1'b0, 24'd10, 32'h0);
        tick();
        set_req(1, 1'b1, 1'b0, 24'd11, 32'h0);
        tick();
        check("late_m0_ack", {bus.m1_ack, bus.m0_ack}, 2'b01);
        check("late_m0_rdata", bus.m0_rdata, 32'hA0A0_A0A0);
        set_req(0, 1'b0, 1'b0, 24'h0, 32'h0);
        tick();
        check("late_done_to_idle", bus.busy, 1'b0);
        tick();
        check("late_m1_grant", {bus.busy, bus.mem_enable, bus.mem_addr}, {2'b11, 24'd11});
        tick();
        check("late_m1_ack", {bus.m1_ack, bus.m0_ack}, 2'b10);
        check("late_m1_rdata", bus.m1_rdata, 32'hB1B1_B1B1);
        check("late_m0_rdata_held", bus.m0_rdata, 32'hA0A0_A0A0);
        set_req(1, 1'b0, 1'b0, 24'h0, 32'h0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
